// File: rtl/osc_pkg.sv
// Shared definitions for the triggered ADC capture path.
//   state_e   : capture/drain controller states (header states only when
//               ADC_FRAME_HEADER_EN is defined)
//   HDR_BYTE0 : first frame-header byte
//   HDR_BYTE1 : second frame-header byte
package osc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StCapture,
    StDrainRd,
    StDrainWait,
    StDrainHold
`ifdef ADC_FRAME_HEADER_EN
    ,
    StHdr0,
    StHdr1
`endif
  } state_e;

  localparam logic [7:0] HDR_BYTE0 = 8'hAA;
  localparam logic [7:0] HDR_BYTE1 = 8'h55;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample store, DEPTH x 8, shaped for block-RAM inference.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : registered read data, valid the cycle after rd_addr is presented
module sample_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  // No reset on the array or the read register so the tools map this to BSRAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered burst capture of the 8-bit ADC bus into block RAM, then byte-wise
// drain into the UART transmitter.
// Optional: define ADC_FRAME_HEADER_EN to prefix each frame with AA,55.
//   clk, rst    : clock; synchronous active-high reset
//   adc_in      : raw ADC bus
//   arm         : one-cycle pulse, starts a capture from IDLE
//   force_trig  : level, triggers immediately while armed
//   trig_level  : trigger threshold
//   trig_rising : 1 = rising crossing, 0 = falling crossing
//   decim       : sample period minus one, in clk cycles
//   tx_ready    : UART transmitter idle
//   tx_data     : byte to transmit
//   tx_send_n   : active-low one-cycle send strobe
//   busy        : high outside IDLE
//   done        : one-cycle pulse after the last byte is strobed
module adc_capture_buffer
  import osc_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = $clog2(DEPTH),
  parameter int unsigned DECIM_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         adc_in,
  input  logic               arm,
  input  logic               force_trig,
  input  logic [7:0]         trig_level,
  input  logic               trig_rising,
  input  logic [DECIM_W-1:0] decim,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_send_n,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [7:0]          cur_q, prev_q;
  logic [DECIM_W-1:0]  decim_q, decim_d, cnt_q, cnt_d;
  logic [7:0]          level_q, level_d;
  logic                rising_q, rising_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, wr_next;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_send_n_q, tx_send_n_d, done_q, done_d;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [7:0]          ram_rdata;
  logic                trig_hit;
`ifdef ADC_FRAME_HEADER_EN
  // 0: sample bytes, 1: AA just sent, 2: 55 just sent
  logic [1:0]          hdr_phase_q, hdr_phase_d;
`endif

  // Input pipeline runs in every state and through reset.
  always_ff @(posedge clk) begin
    cur_q  <= adc_in;
    prev_q <= cur_q;
  end

  // force_trig is OR-ed in so a simultaneous crossing still yields one trigger.
  assign trig_hit = force_trig ||
                    (rising_q ? (prev_q < level_q && cur_q >= level_q)
                              : (prev_q > level_q && cur_q <= level_q));
  assign wr_next  = wr_addr_q + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    decim_d     = decim_q;
    level_d     = level_q;
    rising_d    = rising_q;
    cnt_d       = cnt_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    tx_data_d   = tx_data_q;
    tx_send_n_d = 1'b1;
    done_d      = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = wr_addr_q;
`ifdef ADC_FRAME_HEADER_EN
    hdr_phase_d = hdr_phase_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (arm) begin
          decim_d  = decim;
          level_d  = trig_level;
          rising_d = trig_rising;
          state_d  = StArmed;
        end
      end
      StArmed: begin
        if (trig_hit) begin
          ram_we    = 1'b1;
          ram_waddr = '0;
          wr_addr_d = '0;
          cnt_d     = '0;
          state_d   = StCapture;
        end
      end
      StCapture: begin
        cnt_d = cnt_q + DECIM_W'(1);
        if (cnt_q == decim_q) begin
          cnt_d     = '0;
          ram_we    = 1'b1;
          ram_waddr = wr_next;
          wr_addr_d = wr_next;
          if (wr_next == LastAddr) begin
            rd_addr_d = '0;
`ifdef ADC_FRAME_HEADER_EN
            hdr_phase_d = 2'd0;
            state_d     = StHdr0;
`else
            state_d     = StDrainRd;
`endif
          end
        end
      end
      StDrainRd: begin
        state_d = StDrainWait;
      end
      StDrainWait: begin
        if (tx_ready) begin
          tx_data_d   = ram_rdata;
          tx_send_n_d = 1'b0;
          state_d     = StDrainHold;
        end
      end
`ifdef ADC_FRAME_HEADER_EN
      StHdr0: begin
        if (tx_ready) begin
          tx_data_d   = HDR_BYTE0;
          tx_send_n_d = 1'b0;
          hdr_phase_d = 2'd1;
          state_d     = StDrainHold;
        end
      end
      StHdr1: begin
        if (tx_ready) begin
          tx_data_d   = HDR_BYTE1;
          tx_send_n_d = 1'b0;
          hdr_phase_d = 2'd2;
          state_d     = StDrainHold;
        end
      end
`endif
      // One dead cycle so the UART's ready flag has dropped before we look again.
      StDrainHold: begin
`ifdef ADC_FRAME_HEADER_EN
        if (hdr_phase_q == 2'd1) begin
          state_d = StHdr1;
        end else if (hdr_phase_q == 2'd2) begin
          hdr_phase_d = 2'd0;
          state_d     = StDrainRd;
        end else
`endif
        begin
          if (rd_addr_q == LastAddr) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            state_d   = StDrainRd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      decim_q     <= '0;
      level_q     <= '0;
      rising_q    <= 1'b0;
      cnt_q       <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      tx_data_q   <= 8'h00;
      tx_send_n_q <= 1'b1;
      done_q      <= 1'b0;
`ifdef ADC_FRAME_HEADER_EN
      hdr_phase_q <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      decim_q     <= decim_d;
      level_q     <= level_d;
      rising_q    <= rising_d;
      cnt_q       <= cnt_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      tx_data_q   <= tx_data_d;
      tx_send_n_q <= tx_send_n_d;
      done_q      <= done_d;
`ifdef ADC_FRAME_HEADER_EN
      hdr_phase_q <= hdr_phase_d;
`endif
    end
  end

  sample_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (cur_q),
    .rd_addr (rd_addr_q),
    .rd_data (ram_rdata)
  );

  assign tx_data   = tx_data_q;
  assign tx_send_n = tx_send_n_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Bench for adc_capture_buffer (DEPTH=16). Every ADC value and force_trig
// level seen by the DUT is logged per clock edge; the expected frame is
// derived from that log: find the first edge after arm whose previous two
// samples cross the threshold (or force is high), then take every
// (decim+1)-th logged sample from there.
module tb_adc_capture_buffer;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DECIM_W = 16;
`ifdef ADC_FRAME_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int FRAME = DEPTH + HDR;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         adc_in;
  logic               arm;
  logic               force_trig;
  logic [7:0]         trig_level;
  logic               trig_rising;
  logic [DECIM_W-1:0] decim;
  logic               tx_ready = 1'b1;
  logic [7:0]         tx_data;
  logic               tx_send_n;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  adc_capture_buffer #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .DECIM_W (DECIM_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .adc_in      (adc_in),
    .arm         (arm),
    .force_trig  (force_trig),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .decim       (decim),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_send_n   (tx_send_n),
    .busy        (busy),
    .done        (done)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] adc_log[$];
  logic       force_log[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         done_at_rx = 0;
  int         dup_err = 0;
  int         stab_err = 0;
  int         win_strobes = 0;
  int         ready_phase = 0;
  int         ready_mode = 0;  // 0: always ready, 1: 2 on / 20 off, 2: random
  int         adc_mode = 0;    // 0: hold, 1: ramp up, 2: ramp down, 3: random
  logic [7:0] prev_tx = 8'h00;
  logic       prev_busy = 1'b0;

  always @(posedge clk) begin
    adc_log.push_back(adc_in);
    force_log.push_back(force_trig);
  end

  // Output monitor and tx_ready driver share one process so window accounting
  // is race-free.
  always @(negedge clk) begin
    if (tx_send_n === 1'b0) begin
      rx_q.push_back(tx_data);
      if (win_strobes > 0) dup_err++;
      win_strobes++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_at_rx = rx_q.size();
    end
    if (busy && prev_busy && tx_send_n && tx_data !== prev_tx) stab_err++;
    prev_tx   = tx_data;
    prev_busy = busy;
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: begin
        ready_phase = (ready_phase + 1) % 22;
        if (ready_phase == 0) win_strobes = 0;
        tx_ready = (ready_phase < 2);
      end
      default: tx_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic tick();
    @(negedge clk);
    #1;
    case (adc_mode)
      1: adc_in = adc_in + 8'd1;
      2: adc_in = adc_in - 8'd1;
      3: adc_in = 8'($urandom);
      default: ;
    endcase
  endtask

  task automatic pulse_arm(output int a);
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    a = adc_log.size() - 1;
  endtask

  task automatic wait_done(input int d0, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (done_cnt > d0) ok = 1'b1;
    end
  endtask

  task automatic build_expected(input int a, input logic [7:0] lvl, input bit rising,
                                input int d);
    int         e;
    bit         hit;
    logic [7:0] c;
    logic [7:0] p;
    exp_q.delete();
    e   = a + 1;
    hit = 1'b0;
    while (!hit && e < adc_log.size()) begin
      c = adc_log[e-1];
      p = adc_log[e-2];
      if (force_log[e] || (rising ? (p < lvl && c >= lvl) : (p > lvl && c <= lvl))) hit = 1'b1;
      else e++;
    end
`ifdef ADC_FRAME_HEADER_EN
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
`endif
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (hit && (e - 1 + k * (d + 1)) < adc_log.size()) exp_q.push_back(adc_log[e-1+k*(d+1)]);
      else exp_q.push_back(8'hxx);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data);
    end
    checks++;
    if (tx_send_n !== 1'b1) begin
      errors++; $display("FAIL reset_tx_send_n: got %b want 1", tx_send_n);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", done);
    end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  // Runs one full capture/drain and compares the whole frame against the model.
  task automatic test_frame(input string name, input logic [7:0] lvl, input bit rising,
                            input int d);
    int         a, r0, d0, s0, got_n;
    bit         ok;
    logic [7:0] got;
    r0 = rx_q.size(); d0 = done_cnt; s0 = stab_err;
    trig_level = lvl; trig_rising = rising; decim = DECIM_W'(d);
    pulse_arm(a);
    wait_done(d0, 3000, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s_timeout: got no done, want done", name);
    end
    repeat (4) tick();
    build_expected(a, lvl, rising, d);
    got_n = rx_q.size() - r0;
    checks++;
    if (got_n != FRAME) begin
      errors++; $display("FAIL %s_len: got %0d bytes want %0d", name, got_n, FRAME);
    end
    for (int i = 0; i < FRAME; i++) begin
      got = (r0 + i < rx_q.size()) ? rx_q[r0+i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin
        errors++; $display("FAIL %s_byte%0d: got %h want %h", name, i, got, exp_q[i]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL %s_done_count: got %0d want 1", name, done_cnt - d0);
    end
    checks++;
    if (done_at_rx - r0 != FRAME) begin
      errors++; $display("FAIL %s_done_after: got %0d want %0d", name, done_at_rx - r0, FRAME);
    end
    checks++;
    if (stab_err != s0) begin
      errors++; $display("FAIL %s_tx_stable: got %0d changes want 0", name, stab_err - s0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s_idle_after: got busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_rising();
    ready_mode = 0; adc_mode = 1; adc_in = 8'h70;
    test_frame("rising", 8'h80, 1'b1, 0);
  endtask

  task automatic test_falling_decim();
    ready_mode = 0; adc_mode = 2; adc_in = 8'h50;
    test_frame("falling_decim", 8'h40, 1'b0, 3);
  endtask

  task automatic test_handshake();
    int du0;
    ready_mode = 1; adc_mode = 3; du0 = dup_err;
    test_frame("handshake", 8'($urandom_range(16, 239)), 1'($urandom), $urandom_range(0, 2));
    checks++;
    if (dup_err != du0) begin
      errors++; $display("FAIL handshake_one_per_window: got %0d extra strobes want 0",
                         dup_err - du0);
    end
    ready_mode = 0;
  endtask

  task automatic test_force_and_arm_ignored();
    int         a, r0, d0, got_n;
    bit         ok;
    logic [7:0] got;
    ready_mode = 0; adc_mode = 0; adc_in = 8'h55;
    trig_level = 8'h80; trig_rising = 1'b1; decim = '0;
    r0 = rx_q.size(); d0 = done_cnt;
    force_trig = 1'b1;
    pulse_arm(a);
    tick();
    force_trig = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (rx_q.size() - r0 >= 3) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL force_drain_start: got %0d bytes want >=3", rx_q.size() - r0);
    end
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL force_arm_in_drain_busy: got %b want 1", busy);
    end
    wait_done(d0, 500, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL force_timeout: got no done, want done");
    end
    repeat (4) tick();
    build_expected(a, 8'h80, 1'b1, 0);
    got_n = rx_q.size() - r0;
    checks++;
    if (got_n != FRAME) begin
      errors++; $display("FAIL force_len: got %0d bytes want %0d", got_n, FRAME);
    end
    for (int i = 0; i < FRAME; i++) begin
      got = (r0 + i < rx_q.size()) ? rx_q[r0+i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin
        errors++; $display("FAIL force_byte%0d: got %h want %h", i, got, exp_q[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL force_arm_ignored_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_drain();
    int  r0, d0;
    bit  ok;
    ready_mode = 0; adc_mode = 0; adc_in = 8'h33; force_trig = 1'b1;
    trig_level = 8'h80; trig_rising = 1'b1; decim = 16'd1;
    r0 = rx_q.size(); d0 = done_cnt;
    begin
      int a;
      pulse_arm(a);
    end
    force_trig = 1'b0;
    adc_mode = 3;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      tick();
      if (rx_q.size() - r0 >= 5) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rstmid_reach5: got %0d bytes want 5", rx_q.size() - r0);
    end
    rst = 1'b1;
    arm = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_busy: got %b want 0", busy);
    end
    checks++;
    if (tx_send_n !== 1'b1) begin
      errors++; $display("FAIL rstmid_send_n: got %b want 1", tx_send_n);
    end
    rst = 1'b0;
    arm = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_arm_with_rst: got busy=%b want 0", busy);
    end
    checks++;
    if (done_cnt != d0) begin
      errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - d0);
    end
    adc_mode = 1; adc_in = 8'h10;
    test_frame("rstmid_fresh", 8'h18, 1'b1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      ready_mode = 2; adc_mode = 3;
      test_frame($sformatf("random%0d", n), 8'($urandom_range(16, 239)), 1'($urandom),
                 $urandom_range(0, 2));
    end
    ready_mode = 0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; force_trig = 1'b0; adc_in = 8'h00;
    trig_level = 8'h00; trig_rising = 1'b1; decim = '0;
    repeat (3) tick();
    test_reset();
    test_rising();
    test_falling_decim();
    test_handshake();
    test_force_and_arm_ignored();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_capture_buffer.md
Name: adc_capture_buffer

Overview:
- Upstream stage of the UART transmitter: replaces the free-running 50 Hz single-sample path with triggered burst capture.
- Samples the 8-bit parallel ADC bus, waits for a level-crossing trigger, and stores DEPTH decimated samples in block RAM.
- Drains the frame byte-by-byte into the UART transmitter through its dataOut/sendOnLow-style interface (active-low one-cycle send strobe).

Parameters:
- DEPTH, 256: samples per frame; power of two, 16..4096.
- ADDR_W, 8: $clog2(DEPTH).
- DECIM_W, 16: width of the decimation ratio input.

Ports:
- clk  in  1  system clock, 27 MHz; the ADC is clocked from the same net.
- rst  in  1  synchronous, active-high reset.
- adc_in  in  8  raw ADC bus; bit 7 is MSB.
- arm  in  1  one-cycle pulse; starts a capture when in IDLE.
- force_trig  in  1  level; triggers immediately while ARMED.
- trig_level  in  8  trigger threshold.
- trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger.
- decim  in  DECIM_W  sample period minus one, in clk cycles.
- tx_ready  in  1  high when the UART transmitter is idle.
- tx_data  out  8  byte to transmit.
- tx_send_n  out  1  active-low one-cycle send strobe.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last byte is strobed.

Behaviour:
- Reset values: tx_data=8'h00, tx_send_n=1, busy=0, done=0, state=IDLE. RAM contents are not cleared.
- Input register: adc_in is registered once to produce cur; cur is registered again to produce prev. These registers update every cycle in all states.
- IDLE:
  - arm=1 latches decim, trig_level and trig_rising, then moves to ARMED.
  - arm in any other state is ignored.
- ARMED: trigger is evaluated every clk cycle, with no decimation.
  - Rising trigger: prev < trig_level and cur >= trig_level.
  - Falling trigger: prev > trig_level and cur <= trig_level.
  - force_trig=1 overrides both conditions.
  - On trigger, cur is written to addr 0 in that same cycle, the decimation counter loads 0, and the state moves to CAPTURE.
- CAPTURE:
  - The counter increments each cycle. When it equals the latched decim, cur is written at the next address and the counter resets to 0.
  - decim=0 gives one sample per cycle.
  - After address DEPTH-1 is written, the state moves to DRAIN_RD. Total capture span is DEPTH*(decim+1) cycles from the trigger.
- DRAIN_RD: issues a synchronous RAM read at rd_addr; data is valid next cycle. Moves to DRAIN_WAIT.
- DRAIN_WAIT:
  - When tx_ready=1: tx_data is loaded with the RAM data and tx_send_n=0 for exactly one cycle, then the state moves to DRAIN_HOLD.
  - tx_data is held stable until the next load.
- DRAIN_HOLD:
  - tx_ready is ignored for exactly one cycle to cover the UART's flag latency.
  - If rd_addr == DEPTH-1: done=1, go to IDLE.
  - Otherwise: increment rd_addr, go to DRAIN_RD.
- Addressing: addresses wrap modulo DEPTH; no pre-trigger history is kept.
- Simultaneous events: arm on the same cycle as rst is ignored (rst wins). force_trig together with a crossing produces a single trigger.
- Reset mid-operation: returns to IDLE within one cycle and tx_send_n goes high immediately. A partially sent frame is abandoned and is not resumed.
- Throughput: one byte per UART frame time. At 115200 baud, 256 bytes take about 22 ms.

Optional Feature:
- Macro ADC_FRAME_HEADER_EN.
- Defined: before the first sample, DRAIN sends 8'hAA and then 8'h55, each using the same WAIT/strobe/HOLD handshake. The frame is DEPTH+2 bytes; done fires after the last sample byte.
- Undefined: exactly DEPTH bytes are sent, with no header states or logic.

Decomposition:
- Package osc_pkg holds:
  - the state enum (IDLE, ARMED, CAPTURE, DRAIN_RD, DRAIN_WAIT, DRAIN_HOLD, plus HDR0/HDR1 under the macro);
  - the header constants HDR_BYTE0=8'hAA and HDR_BYTE1=8'h55.
- One sub-module, sample_ram: simple dual-port, synchronous write, registered read, DEPTH x 8, written for BSRAM inference.

Test Plan:
1. Rising trigger: DEPTH=16, decim=0, trig_level=8'h80, adc_in ramps 0x70..0x8F by 1 per cycle, arm -> trigger on cur=0x80. With tx_ready held 1, 16 strobes carry 0x80..0x8F in order, then done pulses once.
2. Falling trigger and decimation: decim=3, trig_rising=0, trig_level=8'h40, adc_in ramps down from 0x50 -> stored samples are 0x40,0x3C,0x38,... (every 4th cycle).
3. Handshake: tx_ready toggles 1 for 2 cycles, 0 for 20 cycles -> exactly one strobe per ready window, tx_data stable between strobes, no byte lost or duplicated.
4. force_trig with adc_in constant 0x55 -> capture starts next cycle and all DEPTH bytes equal 0x55. An arm pulse during DRAIN -> ignored, and busy stays 1.
5. rst asserted while 5 of 16 bytes are sent -> next cycle busy=0, tx_send_n=1. A fresh arm completes a full 16-byte frame.
6. With ADC_FRAME_HEADER_EN defined, rerun scenario 1 -> bytes are AA,55,80..8F (18 strobes), and done fires after 8F.
